bus_out_arbiter: RTL and testbench



---
 rtl/a2bus_pkg.sv | 22 ++
 rtl/prio_encoder.sv | 31 +++
 rtl/bus_out_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_out_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2bus_pkg.sv
// Shared definitions for the Apple II bus-side blocks: output arbiter FSM
// states, conflict counter width and a saturating increment helper.
package a2bus_pkg;

  localparam int CONFLICT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } bus_out_state_t;

  // Saturating increment; the counter sticks at all-ones instead of wrapping.
  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(
    input logic [CONFLICT_CNT_W-1:0] i_val
  );
    logic [CONFLICT_CNT_W-1:0] w_res;
    w_res = (&i_val) ? i_val : i_val + 1'b1;
    return w_res;
  endfunction

endpackage

// File: rtl/prio_encoder.sv
// Fixed-priority encoder: one-hot lowest-index request, plus flags for
// "any request" and "more than one request".
module prio_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_any,
  output logic         o_multi
);

  logic w_seen;

  always_comb begin
    o_grant = '0;
    o_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        if (w_seen) begin
          o_multi = 1'b1;
        end else begin
          o_grant[i] = 1'b1;
        end
        w_seen = 1'b1;
      end
    end
    o_any = w_seen;
  end

endmodule

// File: rtl/bus_out_arbiter.sv
// Arbitrates slot-card requests to drive the Apple II data bus during Phi0,
// holds the bus briefly past Phi1 rise, counts contention and merges IRQs.
module bus_out_arbiter
  import a2bus_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int HOLD_CYCLES         = 2,
  parameter int BUS_DATA_OUT_ENABLE = 1,
  parameter int IRQ_OUT_ENABLE      = 1
) (
  input  logic                      clk_logic,
  input  logic                      system_reset_n,
  input  logic                      phi1_posedge,
  input  logic                      phi1_negedge,
  input  logic [NUM_REQ-1:0]        rd_en_i,
  input  logic [NUM_REQ*8-1:0]      data_i,
  input  logic [NUM_REQ-1:0]        irq_n_i,
  input  logic [NUM_REQ-1:0]        irq_mask_i,
  output logic                      d_dir_o,
  output logic [7:0]                data_o,
  output logic                      irq_n_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic DIR_ON = (BUS_DATA_OUT_ENABLE != 0);

  bus_out_state_t r_state;
  bus_out_state_t w_nextState;

  logic                      r_phi0;
  logic                      r_dir;
  logic [7:0]                r_data;
  logic [NUM_REQ-1:0]        r_grant;
  logic [HOLD_W-1:0]         r_holdCnt;
  logic                      r_contended;
  logic [CONFLICT_CNT_W-1:0] r_conflictCnt;
  logic                      r_irqN;

  logic [NUM_REQ-1:0] w_encGrant;
  logic               w_any;
  logic               w_multi;
  logic [NUM_REQ-1:0] w_sel;
  logic [7:0]         w_selData;
  logic               w_start;
  logic               w_contendNow;
  logic               w_irqActive;

  prio_encoder #(
    .N (NUM_REQ)
  ) u_prio (
    .i_req   (rd_en_i),
    .o_grant (w_encGrant),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  // A request landing on the same cycle as Phi1 rise is too late to be served.
  assign w_start      = (r_state == IDLE) && w_any && r_phi0 && !phi1_posedge;
  assign w_contendNow = w_multi || (|(rd_en_i & ~r_grant));
  assign w_sel        = (r_state == IDLE) ? w_encGrant : r_grant;

  always_comb begin
    w_selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel[i]) begin
        w_selData = w_selData | data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nextState = DRIVE;
        end
      end
      DRIVE: begin
        if (phi1_posedge) begin
          w_nextState = (HOLD_CYCLES == 0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (r_holdCnt == '0) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_phi0 <= 1'b0;
    end else if (phi1_posedge) begin
      r_phi0 <= 1'b0;
    end else if (phi1_negedge) begin
      r_phi0 <= 1'b1;
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_dir         <= 1'b0;
      r_data        <= 8'h00;
      r_grant       <= '0;
      r_holdCnt     <= '0;
      r_contended   <= 1'b0;
      r_conflictCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_grant     <= w_encGrant;
            r_dir       <= DIR_ON;
            r_data      <= w_selData;
            r_contended <= 1'b0;
          end
        end
        DRIVE: begin
          // Cards may settle their byte late in Phi0, so keep re-sampling.
          r_data <= w_selData;
          if (w_contendNow) begin
            r_contended <= 1'b1;
          end
          if (phi1_posedge) begin
            if (r_contended || w_contendNow) begin
              r_conflictCnt <= sat_inc(r_conflictCnt);
            end
            r_holdCnt <= HOLD_LOAD;
            if (HOLD_CYCLES == 0) begin
              r_dir   <= 1'b0;
              r_grant <= '0;
            end
          end
        end
        HOLD: begin
          if (r_holdCnt == '0) begin
            r_dir   <= 1'b0;
            r_grant <= '0;
          end else begin
            r_holdCnt <= r_holdCnt - HOLD_W'(1);
          end
        end
        default: begin
          r_dir   <= 1'b0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign w_irqActive = |(~irq_n_i & irq_mask_i);

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_irqN <= 1'b1;
    end else begin
      r_irqN <= (IRQ_OUT_ENABLE != 0) ? ~w_irqActive : 1'b1;
    end
  end

  assign d_dir_o        = r_dir;
  assign data_o         = r_data;
  assign grant_o        = r_grant;
  assign irq_n_o        = r_irqN;
  assign conflict_cnt_o = r_conflictCnt;

endmodule

// File: tb/tb_bus_out_arbiter.sv
// Directed bench for bus_out_arbiter: a scoreboard checks each presented bus
// drive, while the stimulus thread checks timing, counters, IRQ and reset.
module tb_bus_out_arbiter;

  logic        clk;
  logic        rstN;
  logic        phi1Pos;
  logic        phi1Neg;
  logic [3:0]  rdEn;
  logic [31:0] dataIn;
  logic [3:0]  irqNIn;
  logic [3:0]  irqMask;

  logic        dirA, dirB;
  logic [7:0]  dataA, dataB;
  logic        irqA, irqB;
  logic [3:0]  grantA, grantB;
  logic [7:0]  cntA, cntB;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
  } expT;

  expT expQ[$];

  int testsRun  = 0;
  int failCount = 0;

  logic       prevDir;
  logic [7:0] prevData;
  logic [3:0] prevGrant;
  int         expCnt;

  bus_out_arbiter #(
    .NUM_REQ(4), .HOLD_CYCLES(2), .BUS_DATA_OUT_ENABLE(1), .IRQ_OUT_ENABLE(1)
  ) dutA (
    .clk_logic(clk), .system_reset_n(rstN),
    .phi1_posedge(phi1Pos), .phi1_negedge(phi1Neg),
    .rd_en_i(rdEn), .data_i(dataIn), .irq_n_i(irqNIn), .irq_mask_i(irqMask),
    .d_dir_o(dirA), .data_o(dataA), .irq_n_o(irqA),
    .grant_o(grantA), .conflict_cnt_o(cntA)
  );

  bus_out_arbiter #(
    .NUM_REQ(4), .HOLD_CYCLES(2), .BUS_DATA_OUT_ENABLE(0), .IRQ_OUT_ENABLE(0)
  ) dutB (
    .clk_logic(clk), .system_reset_n(rstN),
    .phi1_posedge(phi1Pos), .phi1_negedge(phi1Neg),
    .rd_en_i(rdEn), .data_i(dataIn), .irq_n_i(irqNIn), .irq_mask_i(irqMask),
    .d_dir_o(dirB), .data_o(dataB), .irq_n_o(irqB),
    .grant_o(grantB), .conflict_cnt_o(cntB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseNeg();
    phi1Neg = 1'b1;
    tick();
    phi1Neg = 1'b0;
  endtask

  // Full bus cycle: Phi0 start, request, three drive cycles, Phi1 rise, hold.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] expGrant,
                               input logic [7:0] expData, input bit checkRelease);
    rdEn = 4'b0000;
    pulseNeg();
    expQ.push_back('{grant: expGrant, data: expData});
    rdEn = req;
    tick();
    tick();
    tick();
    tick();
    phi1Pos = 1'b1;
    rdEn    = 4'b0000;
    tick();
    phi1Pos = 1'b0;
    if (checkRelease) begin
      checkOutput("dirHoldE0", dirA, 1);
      tick();
      checkOutput("dirHoldE1", dirA, 1);
      tick();
      checkOutput("dirReleased", dirA, 0);
      checkOutput("grantReleased", grantA, 0);
      checkOutput("dataKept", dataA, expData);
    end else begin
      tick();
      tick();
    end
    tick();
  endtask

  // Scoreboard monitor: every new drive presentation pops one expectation.
  always @(negedge clk) begin
    if (!rstN) begin
      prevDir   = 1'b0;
      prevData  = 8'h00;
      prevGrant = 4'b0000;
    end else begin
      checkOutput("dirDisabledInst", dirB, 0);
      checkOutput("irqDisabledInst", irqB, 1);
      if (dirA && (!prevDir || dataA != prevData || grantA != prevGrant)) begin
        if (expQ.size() == 0) begin
          testsRun++;
          failCount++;
          $display("[TB] FAIL unexpectedDrive: got grant %0h data %0h, expected no drive",
                   grantA, dataA);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("sbGrant", grantA, e.grant);
          checkOutput("sbData", dataA, e.data);
        end
      end
      prevDir   = dirA;
      prevData  = dataA;
      prevGrant = grantA;
    end
  end

  initial begin
    rstN    = 1'b0;
    phi1Pos = 1'b0;
    phi1Neg = 1'b0;
    rdEn    = 4'b0000;
    dataIn  = 32'h0;
    irqNIn  = 4'b1111;
    irqMask = 4'b0000;
    expCnt  = 0;

    #12;
    checkOutput("rstDir", dirA, 0);
    checkOutput("rstData", dataA, 8'h00);
    checkOutput("rstGrant", grantA, 0);
    checkOutput("rstIrq", irqA, 1);
    checkOutput("rstCnt", cntA, 0);
    tick();
    rstN = 1'b1;
    tick();

    irqNIn  = 4'b1110;
    irqMask = 4'b1110;
    tick();
    checkOutput("irqMasked", irqA, 1);
    irqMask = 4'b0001;
    tick();
    checkOutput("irqAsserted", irqA, 0);
    checkOutput("irqForcedHigh", irqB, 1);

    dataIn[15:8] = 8'hA5;
    applyStimulus(4'b0010, 4'b0010, 8'hA5, 1'b1);
    checkOutput("singleCnt", cntA, 0);

    // Late-settling data from the winner, which also drops its request early.
    dataIn[15:8] = 8'h11;
    pulseNeg();
    expQ.push_back('{grant: 4'b0010, data: 8'h11});
    expQ.push_back('{grant: 4'b0010, data: 8'h22});
    rdEn = 4'b0010;
    tick();
    checkOutput("lateFirst", dataA, 8'h11);
    tick();
    dataIn[15:8] = 8'h22;
    rdEn = 4'b0000;
    tick();
    checkOutput("lateData", dataA, 8'h22);
    checkOutput("lateGrant", grantA, 4'b0010);
    checkOutput("lateDir", dirA, 1);
    phi1Pos = 1'b1;
    tick();
    phi1Pos = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("lateCnt", cntA, 0);

    // Requests outside Phi0 must be ignored.
    rdEn = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("phi1OnlyDir", dirA, 0);
      checkOutput("phi1OnlyGrant", grantA, 0);
    end
    rdEn = 4'b0000;
    pulseNeg();
    rdEn    = 4'b0100;
    phi1Pos = 1'b1;
    tick();
    phi1Pos = 1'b0;
    checkOutput("lateReqDir", dirA, 0);
    checkOutput("lateReqGrant", grantA, 0);
    tick();
    checkOutput("lateReqDir2", dirA, 0);
    rdEn = 4'b0000;
    tick();

    // Contention: two cards each cycle, lower index wins; counter saturates.
    dataIn[15:8]  = 8'h5A;
    dataIn[23:16] = 8'h77;
    for (int n = 1; n <= 300; n++) begin
      applyStimulus(4'b0110, 4'b0010, 8'h5A, (n == 1));
      expCnt = (expCnt < 255) ? expCnt + 1 : 255;
      if (n == 1 || n == 254 || n == 255 || n == 300) begin
        checkOutput("conflictCnt", cntA, expCnt[7:0]);
      end
    end
    checkOutput("conflictSat", cntA, 8'd255);

    // Asynchronous reset in the middle of a drive.
    dataIn[31:24] = 8'h3C;
    pulseNeg();
    expQ.push_back('{grant: 4'b1000, data: 8'h3C});
    rdEn = 4'b1000;
    tick();
    checkOutput("preRstGrant", grantA, 4'b1000);
    tick();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstDir", dirA, 0);
    checkOutput("midRstGrant", grantA, 0);
    checkOutput("midRstData", dataA, 8'h00);
    checkOutput("midRstCnt", cntA, 0);
    checkOutput("midRstIrq", irqA, 1);
    rdEn = 4'b0000;
    #3;
    rstN = 1'b1;
    tick();
    checkOutput("postRstIrq", irqA, 0);

    dataIn[7:0] = 8'hC3;
    applyStimulus(4'b1001, 4'b0001, 8'hC3, 1'b1);
    checkOutput("postRstCnt", cntA, 1);

    tick();
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
